// File: rtl/wash_pkg.sv
// Shared types for the wash sequencer: FSM state encoding, program codes,
// phase-duration selection and actuator decode.
package wash_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOAP_WAIT,
    S_FILL,
    S_WASH,
    S_DRAIN,
    S_RINSE_FILL,
    S_RINSE,
    S_SPIN,
    S_DONE,
    S_PAUSED
  } state_e;

  localparam logic [2:0] PRG_COLD      = 3'b000;
  localparam logic [2:0] PRG_HOT       = 3'b001;
  localparam logic [2:0] PRG_RINSE_DRY = 3'b010;
  localparam logic [2:0] PRG_DRY       = 3'b011;

  typedef struct packed {
    logic cold;
    logic hot;
    logic drain;
    logic motor;
  } act_t;

  // Ticks a state runs for; non-timed states report 0 so the display blanks.
  function automatic int unsigned phase_dur(
    input state_e      s,
    input int unsigned fill_t,
    input int unsigned wash_t,
    input int unsigned rinse_t,
    input int unsigned drain_t,
    input int unsigned spin_t,
    input int unsigned soap_to
  );
    case (s)
      S_SOAP_WAIT:          return soap_to;
      S_FILL, S_RINSE_FILL: return fill_t;
      S_WASH:               return wash_t;
      S_RINSE:              return rinse_t;
      S_DRAIN:              return drain_t;
      S_SPIN:               return spin_t;
      default:              return 0;
    endcase
  endfunction

  function automatic act_t decode_act(input state_e s, input logic [2:0] prog);
    act_t a;
    a = '0;
    case (s)
      S_FILL: begin
        if (prog == PRG_HOT) a.hot = 1'b1;
        else                 a.cold = 1'b1;
      end
      S_RINSE_FILL:    a.cold  = 1'b1;
      S_WASH, S_RINSE: a.motor = 1'b1;
      S_DRAIN:         a.drain = 1'b1;
      S_SPIN: begin
        a.motor = 1'b1;
        a.drain = 1'b1;
      end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Timer prescaler: one-cycle tick every TICK_DIV clocks, held cleared while clr is high.
module wash_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q == LAST) cnt_d = '0;
    else                      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: fill/wash/drain/rinse/spin phases with
// door pause, soap wait with timeout and sticky error reporting.
module wash_sequencer #(
  parameter int unsigned TIMER_W      = 8,
  parameter int unsigned TICK_DIV     = 1,
  parameter int unsigned FILL_T       = 4,
  parameter int unsigned WASH_T       = 6,
  parameter int unsigned RINSE_T      = 4,
  parameter int unsigned DRAIN_T      = 3,
  parameter int unsigned SPIN_T       = 5,
  parameter int unsigned RINSE_CYCLES = 1,
  parameter int unsigned SOAP_TO      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               power,
  input  logic [2:0]         program_selection,
  input  logic               start,
  input  logic               doorclosed,
  input  logic               soap,
  output logic               valve_in_cold,
  output logic               valve_in_hot,
  output logic               valve_out,
  output logic               motor,
  output logic [TIMER_W-1:0] timer_display,
  output logic               program_done,
  output logic               soap_warning,
  output logic               paused,
  output logic               error
);

  import wash_pkg::*;

  localparam int unsigned RC_W = $clog2(RINSE_CYCLES + 1);

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;
  logic [2:0]         prog_q, prog_d;
  logic [RC_W-1:0]    rinse_q, rinse_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               error_q, error_d;
  logic               done_q, done_d;
  act_t               act_q, act_d;
  logic               tick, tick_clr;

  assign tick_clr = (state_q == S_IDLE) || (state_q == S_PAUSED);

  wash_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  function automatic logic [TIMER_W-1:0] dur(input state_e s);
    return TIMER_W'(phase_dur(s, FILL_T, WASH_T, RINSE_T, DRAIN_T, SPIN_T, SOAP_TO));
  endfunction

  // rinse_q counts rinse loops started; the post-wash drain sees 0 and so always rinses.
  function automatic state_e after_phase(input state_e s, input logic [RC_W-1:0] rc);
    case (s)
      S_FILL:       return S_WASH;
      S_WASH:       return S_DRAIN;
      S_DRAIN:      return (32'(rc) < RINSE_CYCLES) ? S_RINSE_FILL : S_SPIN;
      S_RINSE_FILL: return S_RINSE;
      S_RINSE:      return S_DRAIN;
      S_SPIN:       return S_DONE;
      default:      return S_IDLE;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    prog_d  = prog_q;
    rinse_d = rinse_q;
    timer_d = timer_q;
    error_d = error_q;
    done_d  = done_q;

    if (!power) begin
      state_d = S_IDLE;
      timer_d = '0;
      error_d = 1'b0;
      done_d  = 1'b0;
      rinse_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (doorclosed && start) begin
            prog_d  = program_selection;
            error_d = 1'b0;
            done_d  = 1'b0;
            rinse_d = '0;
            case (program_selection)
              PRG_COLD, PRG_HOT: state_d = soap ? S_FILL : S_SOAP_WAIT;
              PRG_RINSE_DRY: begin
                state_d = S_RINSE_FILL;
                rinse_d = RC_W'(1);
              end
              PRG_DRY: state_d = S_SPIN;
              default: begin
                state_d = S_IDLE;
                error_d = 1'b1;
              end
            endcase
            timer_d = dur(state_d);
          end
        end
        S_SOAP_WAIT: begin
          if (!doorclosed) begin
            state_d = S_PAUSED;
            ret_d   = state_q;
          end else if (soap) begin
            state_d = S_FILL;
            timer_d = dur(S_FILL);
          end else if (tick) begin
            if (timer_q == TIMER_W'(1)) begin
              state_d = S_IDLE;
              timer_d = '0;
              error_d = 1'b1;
            end else begin
              timer_d = timer_q - TIMER_W'(1);
            end
          end
        end
        S_FILL, S_WASH, S_DRAIN, S_RINSE_FILL, S_RINSE, S_SPIN: begin
          if (!doorclosed) begin
            state_d = S_PAUSED;
            ret_d   = state_q;
          end else if (tick) begin
            if (timer_q == TIMER_W'(1)) begin
              state_d = after_phase(state_q, rinse_q);
              timer_d = dur(state_d);
              if (state_d == S_RINSE_FILL) rinse_d = rinse_q + RC_W'(1);
              if (state_d == S_DONE)       done_d  = 1'b1;
            end else begin
              timer_d = timer_q - TIMER_W'(1);
            end
          end
        end
        S_PAUSED: begin
          if (doorclosed) state_d = ret_q;
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end

    act_d = decode_act(state_d, prog_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      prog_q  <= '0;
      rinse_q <= '0;
      timer_q <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      prog_q  <= prog_d;
      rinse_q <= rinse_d;
      timer_q <= timer_d;
      error_q <= error_d;
      done_q  <= done_d;
      act_q   <= act_d;
    end
  end

  assign valve_in_cold = act_q.cold;
  assign valve_in_hot  = act_q.hot;
  assign valve_out     = act_q.drain;
  assign motor         = act_q.motor;
  assign timer_display = timer_q;
  assign program_done  = done_q;
  assign error         = error_q;
  assign soap_warning  = (state_q == S_SOAP_WAIT);
  assign paused        = (state_q == S_PAUSED);

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: default instance plus a two-rinse, divide-by-3 instance.
module tb_wash_sequencer;

  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_COLD = 8'b1000_0000;
  localparam logic [7:0] O_HOT  = 8'b0100_0000;
  localparam logic [7:0] O_VOUT = 8'b0010_0000;
  localparam logic [7:0] O_MOT  = 8'b0001_0000;
  localparam logic [7:0] O_SPIN = 8'b0011_0000;
  localparam logic [7:0] O_DONE = 8'b0000_1000;
  localparam logic [7:0] O_WARN = 8'b0000_0100;
  localparam logic [7:0] O_PAUS = 8'b0000_0010;
  localparam logic [7:0] O_ERR  = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       rst_n, power, start, doorclosed, soap;
  logic [2:0] sel;

  logic       c1, h1, v1, m1, d1, w1, p1, e1;
  logic       c2, h2, v2, m2, d2, w2, p2, e2;
  logic [7:0] tmr1, tmr2;
  logic [7:0] outs1, outs2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  assign outs1 = {c1, h1, v1, m1, d1, w1, p1, e1};
  assign outs2 = {c2, h2, v2, m2, d2, w2, p2, e2};

  always #5 clk = ~clk;

  wash_sequencer dut1 (
    .clk(clk), .rst_n(rst_n), .power(power), .program_selection(sel),
    .start(start), .doorclosed(doorclosed), .soap(soap),
    .valve_in_cold(c1), .valve_in_hot(h1), .valve_out(v1), .motor(m1),
    .timer_display(tmr1), .program_done(d1), .soap_warning(w1),
    .paused(p1), .error(e1)
  );

  wash_sequencer #(
    .RINSE_CYCLES(2),
    .TICK_DIV(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .power(power), .program_selection(sel),
    .start(start), .doorclosed(doorclosed), .soap(soap),
    .valve_in_cold(c2), .valve_in_hot(h2), .valve_out(v2), .motor(m2),
    .timer_display(tmr2), .program_done(d2), .soap_warning(w2),
    .paused(p2), .error(e2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks outputs and countdown for n ticks of a phase, starting from display value top.
  task automatic phase(input string tag, input bit use2, input logic [7:0] exp,
                       input int unsigned top, input int unsigned n, input int unsigned div);
    for (int unsigned i = 0; i < n * div; i++) begin
      chk({tag, "_out"}, use2 ? 32'(outs2) : 32'(outs1), 32'(exp));
      chk({tag, "_tmr"}, use2 ? 32'(tmr2) : 32'(tmr1), top - i / div);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; power = 1'b1; start = 1'b0; doorclosed = 1'b1; soap = 1'b1; sel = 3'b000;
    step();
    step();
    chk("rst_out1", 32'(outs1), 32'(O_NONE));
    chk("rst_tmr1", 32'(tmr1), 32'd0);
    chk("rst_out2", 32'(outs2), 32'(O_NONE));
    rst_n = 1'b1;
    step();
    chk("idle_out1", 32'(outs1), 32'(O_NONE));

    // Cold wash, soap present: full phase sequence, never the hot valve
    sel = 3'b000; start = 1'b1;
    step();
    start = 1'b0;
    phase("t1_fill",   0, O_COLD, 4, 4, 1);
    phase("t1_wash",   0, O_MOT,  6, 6, 1);
    phase("t1_drain",  0, O_VOUT, 3, 3, 1);
    phase("t1_rfill",  0, O_COLD, 4, 4, 1);
    phase("t1_rinse",  0, O_MOT,  4, 4, 1);
    phase("t1_drain2", 0, O_VOUT, 3, 3, 1);
    phase("t1_spin",   0, O_SPIN, 5, 5, 1);
    chk("t1_done", 32'(outs1), 32'(O_DONE));
    chk("t1_done_tmr", 32'(tmr1), 32'd0);
    step();
    chk("t1_done_hold", 32'(outs1), 32'(O_DONE));

    // Hot wash waiting for soap, then a door pause in WASH at display 3
    soap = 1'b0; sel = 3'b001; start = 1'b1;
    step();
    start = 1'b0;
    phase("t2_wait", 0, O_WARN, 8, 3, 1);
    soap = 1'b1;
    step();
    phase("t2_fill", 0, O_HOT, 4, 4, 1);
    phase("t3_wash_a", 0, O_MOT, 6, 3, 1);
    chk("t3_at3_out", 32'(outs1), 32'(O_MOT));
    chk("t3_at3_tmr", 32'(tmr1), 32'd3);
    doorclosed = 1'b0;
    step();
    phase("t3_pause", 0, O_PAUS, 3, 1, 1);
    phase("t3_pause2", 0, O_PAUS, 3, 1, 1);
    doorclosed = 1'b1;
    step();
    phase("t3_wash_b", 0, O_MOT,  3, 3, 1);
    phase("t3_drain",  0, O_VOUT, 3, 3, 1);
    phase("t3_rfill",  0, O_COLD, 4, 4, 1);
    phase("t3_rinse",  0, O_MOT,  4, 4, 1);
    phase("t3_drain2", 0, O_VOUT, 3, 3, 1);
    phase("t3_spin",   0, O_SPIN, 5, 5, 1);
    chk("t3_done", 32'(outs1), 32'(O_DONE));

    // Soap never arrives: timeout after 8 cycles
    soap = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    phase("t2_to", 0, O_WARN, 8, 8, 1);
    chk("t2_to_err", 32'(outs1), 32'(O_ERR));
    chk("t2_to_tmr", 32'(tmr1), 32'd0);

    // Soap on the timeout tick wins, then power-off aborts
    start = 1'b1;
    step();
    start = 1'b0;
    phase("t2_sw", 0, O_WARN, 8, 7, 1);
    chk("t2_last_tmr", 32'(tmr1), 32'd1);
    soap = 1'b1;
    step();
    chk("t2_late_soap_out", 32'(outs1), 32'(O_HOT));
    chk("t2_late_soap_tmr", 32'(tmr1), 32'd4);
    power = 1'b0;
    step();
    chk("t2_pwr_out", 32'(outs1), 32'(O_NONE));
    chk("t2_pwr_tmr", 32'(tmr1), 32'd0);
    power = 1'b1;

    // Invalid program sets error; a valid dry start clears it
    sel = 3'b111; start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_inv", 32'(outs1), 32'(O_ERR));
    chk("t4_inv_tmr", 32'(tmr1), 32'd0);
    step();
    chk("t4_inv_hold", 32'(outs1), 32'(O_ERR));
    sel = 3'b011; start = 1'b1;
    step();
    start = 1'b0;
    phase("t4_spin", 0, O_SPIN, 5, 5, 1);
    chk("t4_done", 32'(outs1), 32'(O_DONE));

    // Power drop during SPIN; door open blocks start
    start = 1'b1;
    step();
    start = 1'b0;
    phase("t5_spin", 0, O_SPIN, 5, 2, 1);
    power = 1'b0;
    step();
    chk("t5_pwr_out", 32'(outs1), 32'(O_NONE));
    chk("t5_pwr_tmr", 32'(tmr1), 32'd0);
    power = 1'b1; doorclosed = 1'b0; start = 1'b1;
    step();
    chk("t5_door_blk", 32'(outs1), 32'(O_NONE));
    step();
    chk("t5_door_blk2", 32'(outs1), 32'(O_NONE));
    start = 1'b0; doorclosed = 1'b1;

    // Async reset mid-RINSE clears outputs without a clock edge
    sel = 3'b010; start = 1'b1;
    step();
    start = 1'b0;
    phase("t5_rfill", 0, O_COLD, 4, 4, 1);
    phase("t5_rinse", 0, O_MOT, 4, 2, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out", 32'(outs1), 32'(O_NONE));
    chk("t5_rst_tmr", 32'(tmr1), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_post_rst", 32'(outs1), 32'(O_NONE));

    // Two rinse loops at one tick per 3 clocks
    sel = 3'b010; start = 1'b1;
    step();
    start = 1'b0;
    phase("t6_rfill",  1, O_COLD, 4, 4, 3);
    phase("t6_rinse",  1, O_MOT,  4, 4, 3);
    phase("t6_drain",  1, O_VOUT, 3, 3, 3);
    phase("t6_rfill2", 1, O_COLD, 4, 4, 3);
    phase("t6_rinse2", 1, O_MOT,  4, 4, 3);
    phase("t6_drain2", 1, O_VOUT, 3, 3, 3);
    phase("t6_spin",   1, O_SPIN, 5, 5, 3);
    chk("t6_done", 32'(outs2), 32'(O_DONE));
    chk("t6_done_tmr", 32'(tmr2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
